// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder with valid/ready handshake.
// The operands are split into STAGES chunks of C bits. Stage k adds chunk k,
// using the carry registered by stage k-1. Each stage register carries the
// lower sum chunks already finished plus the upper operand chunks still to be
// added. The upper operands are stored shifted right, so the next chunk to add
// always sits at bits [C-1:0].
// The ready chain lets bubbles collapse under backpressure, so the pipeline can
// hold STAGES results before in_ready drops.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int C   = WIDTH / STAGES;
    localparam int OPN = (STAGES > 1) ? STAGES - 1 : 1;

    // Per-stage registers. The last stage keeps no operands.
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  a_q   [OPN];
    logic [WIDTH-1:0]  b_q   [OPN];

    // What each stage sees at its input: the previous register, or the ports for stage 0.
    logic [STAGES-1:0] st_v;
    logic [STAGES-1:0] st_c;
    logic [WIDTH-1:0]  st_a   [STAGES];
    logic [WIDTH-1:0]  st_b   [STAGES];
    logic [WIDTH-1:0]  st_sum [STAGES];

    logic [STAGES-1:0] load;
    logic [STAGES-1:0] add_co;
    logic [WIDTH-1:0]  add_chunk [STAGES];

    // C-cell ripple chain of full-adder cells; returns {carry_out, sum_chunk}.
    function automatic logic [C:0] ripple(input logic [C-1:0] x,
                                          input logic [C-1:0] y,
                                          input logic         ci);
        logic         c;
        logic [C-1:0] s;
        c = ci;
        s = '0;
        for (int i = 0; i < C; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    // Route the ports into stage 0 and each register into the stage after it.
    always_comb begin
        st_v[0]   = in_valid;
        st_c[0]   = cin;
        st_a[0]   = a;
        st_b[0]   = b;
        st_sum[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            st_v[k]   = v_q[k-1];
            st_c[k]   = c_q[k-1];
            st_a[k]   = a_q[k-1];
            st_b[k]   = b_q[k-1];
            st_sum[k] = sum_q[k-1];
        end
    end

    // Add this stage's chunk and place it at its final bit position in the sum.
    always_comb begin
        logic [C:0] r;
        add_co = '0;
        for (int k = 0; k < STAGES; k++) begin
            r            = ripple(st_a[k][C-1:0], st_b[k][C-1:0], st_c[k]);
            add_co[k]    = r[C];
            add_chunk[k] = WIDTH'(r[C-1:0]) << (k * C);
        end
    end

    // Ready chain: a stage loads when it is empty or its successor takes its
    // contents this cycle.
    always_comb begin
        load             = '0;
        load[STAGES-1]   = !v_q[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            load[k] = !v_q[k] || load[k+1];
        end
    end

    // Stage registers. Data is captured only with a valid predecessor. A stage
    // that loads from a bubble just clears its valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= '0;
            end
            for (int k = 0; k < OPN; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    v_q[k] <= st_v[k];
                    if (st_v[k]) begin
                        c_q[k]   <= add_co[k];
                        sum_q[k] <= st_sum[k] | add_chunk[k];
                    end
                end
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                if (load[k] && st_v[k]) begin
                    a_q[k] <= st_a[k] >> C;
                    b_q[k] <= st_b[k] >> C;
                end
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = v_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = c_q[STAGES-1];

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the operand and sum width in bits.
REQ-002 The module SHALL have parameter STAGES, default 4, giving the number of pipeline stages; WIDTH SHALL be an integer multiple of STAGES, with chunk size C = WIDTH/STAGES.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The module SHALL have port in_valid, input, 1 bit: the operands on a, b and cin are valid.
REQ-006 The module SHALL have port in_ready, output, 1 bit: stage 0 can accept an operation this cycle.
REQ-007 The module SHALL have ports a and b, input, WIDTH bits each: the unsigned operands.
REQ-008 The module SHALL have port cin, input, 1 bit: the carry-in.
REQ-009 The module SHALL have port out_valid, output, 1 bit: sum and cout hold a valid result.
REQ-010 The module SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-011 The module SHALL have port sum, output, WIDTH bits: the result sum.
REQ-012 The module SHALL have port cout, output, 1 bit: the result carry-out.

Function
REQ-013 The module SHALL compute {cout,sum} = a + b + cin exactly, with a (WIDTH+1)-bit unsigned result and no saturation.
REQ-014 Stage k (0..STAGES-1) SHALL add operand bits [k*C +: C] using a C-cell ripple chain of full-adder cells (sum = a^b^c, carry = ab | c(a^b)).
REQ-015 The carry into stage k SHALL be the registered carry-out of stage k-1; stage 0 SHALL use cin.
REQ-016 Each stage register SHALL hold: the valid bit, the carry, the completed lower sum chunks, and the not-yet-used upper operand chunks (skew/deskew).
REQ-017 The last stage's registers SHALL drive out_valid, sum and cout directly.
REQ-018 A transfer SHALL occur on input when in_valid && in_ready, and on output when out_valid && out_ready.
REQ-019 Stage k SHALL load from stage k-1 when its valid bit is 0 or stage k+1 loads from it; the last stage SHALL load when out_valid is 0 or out_ready is 1.
REQ-020 in_ready SHALL equal the stage-0 load condition; a combinational path from out_ready to in_ready is permitted.
REQ-021 A stage that loads from an empty predecessor SHALL clear its valid bit (bubble); no result SHALL be duplicated or dropped.
REQ-022 Latency with out_ready = 1 SHALL be exactly STAGES cycles: an input accepted at edge N gives out_valid = 1 after edge N+STAGES-1 (WIDTH=16, STAGES=4: visible in the cycle after edge N+3).
REQ-023 Throughput SHALL be one operation per cycle when out_ready is held 1.
REQ-024 Results SHALL leave in acceptance order.
REQ-025 While out_valid && !out_ready, sum and cout SHALL stay stable.
REQ-026 Internal bubbles SHALL collapse under backpressure, so the pipeline holds up to STAGES operations before in_ready goes to 0.
REQ-027 a, b and cin SHALL be ignored when in_valid = 0 or in_ready = 0.
REQ-028 With an empty pipeline, an input accepted while out_ready = 0 SHALL advance to the last stage and wait there.

Reset
REQ-029 While rst_n = 0, all stage valid bits, out_valid, sum, cout and all internal carries and data SHALL be 0.
REQ-030 In the first cycle after reset is released, in_ready SHALL be 1.
REQ-031 Asserting reset mid-operation SHALL discard all in-flight operations immediately and produce no result.

Verification (WIDTH=16, STAGES=4)
REQ-032 Full carry propagation: a=0xFFFF, b=0x0001, cin=0, out_ready=1 -> exactly 4 cycles later one beat with sum=0x0000, cout=1.
REQ-033 Carry-in handling: a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; also a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
REQ-034 Streaming: 8 back-to-back operations (a=i, b=0x8000+i, i=0..7) with out_ready=1 -> 8 consecutive out_valid beats starting at latency 4, in order, sum=0x8000+2i.
REQ-035 Backpressure: out_ready=0 with in_valid held 1 -> in_ready drops after 4 acceptances and the output is held stable; out_ready=1 -> all results delivered in order with no loss or repeat.
REQ-036 Reset mid-flight: rst_n pulled low with 3 operations in flight -> out_valid=0 immediately and no stale beat after release; in_ready=1 on the next cycle.
REQ-037 Random: 10k random a, b, cin with random in_valid/out_ready -> every beat matches the a+b+cin scoreboard, in order, with count equality.
